renode_apb3_manager: RTL and testbench
======================================

Name: renode_apb3_manager

Overview:
APB3 requester stage placed directly upstream of the Renode APB3 interface signal bundle. It accepts single read/write requests from the co-simulation transaction side on a valid/ready channel. It sequences each request through the APB3 SETUP and ACCESS phases and returns read data and an error flag on a valid/ready response channel. Only one transfer is in flight at a time; no pipelining across transfers.

Parameters:
AddressWidth, 20, width of req_addr/paddr
DataWidth, 32, width of data buses; legal values 8, 16, 24, 32; any other value is an elaboration-time $error
TimeoutCycles, 256, ACCESS-phase wait limit (used only with the optional feature); must be >= 1

Ports:
pclk  in  1  single clock for all logic
rst  in  1  synchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready
req_addr  in  AddressWidth  transfer address
req_write  in  1  1 = write, 0 = read
req_wdata  in  DataWidth  write data
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_rdata  out  DataWidth  read data; 0 for writes
rsp_error  out  1  pslverr or timeout
presetn  out  1  APB reset to completer, registered ~rst
paddr  out  AddressWidth  APB address
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  DataWidth  APB write data
pready  in  1  completer ready
prdata  in  DataWidth  completer read data
pslverr  in  1  completer error

Behaviour:
- Interface decision: one clock, pclk; reset rst is synchronous and active-high.
- All outputs are registered, except req_ready, which is decoded from state.
- Reset values: state IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, presetn=0.
- presetn: presetn <= ~rst, so it goes high one cycle after rst deasserts.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: req_ready=1. On handshake, latch addr/write/wdata into paddr/pwrite/pwdata; pwdata=0 for reads. Set psel=1, penable=0, then go to SETUP.
- SETUP: lasts exactly one cycle. Set penable=1, then go to ACCESS.
- ACCESS, pready=0: hold all APB outputs stable (wait state).
- ACCESS, pready=1:
  - psel=0, penable=0.
  - rsp_rdata = pwrite ? 0 : prdata.
  - rsp_error = pslverr.
  - rsp_valid=1, then go to RESP.
- RESP: hold rsp_* stable until rsp_ready. On handshake, rsp_valid=0 and go to IDLE. req_ready is 0 in SETUP, ACCESS and RESP.
- Latency with zero wait states and rsp_ready=1: request accepted at cycle N; SETUP visible N+1; ACCESS N+2; rsp_valid N+3; next request accepted N+4. Each pready-low cycle adds one cycle.
- Between transfers, paddr, pwrite and pwdata hold their last values; psel=0.
- pslverr is sampled only in the ACCESS cycle with pready=1. pslverr on reads still captures prdata.
- Reset mid-transfer: abort immediately to reset values. Any latched request or pending response is discarded; no response is generated.
- rsp_ready asserted while rsp_valid=0 is ignored. req_valid deasserting without a handshake is legal.

Optional Feature:
Macro: RENODE_APB3_MANAGER_TIMEOUT_EN.
- Enabled: a counter clears on entering ACCESS and increments each ACCESS cycle with pready=0. When TimeoutCycles consecutive pready-low cycles have elapsed:
  - drop psel/penable;
  - rsp_error=1, rsp_rdata=0, rsp_valid=1;
  - go to RESP.
  - If pready=1 arrives in the same cycle the limit is reached, the normal completion wins.
  - The counter saturates and is not visible externally.
- Disabled: no counter logic; ACCESS waits for pready indefinitely.

Test Plan:
- Write 0x00010 <- 0xDEADBEEF, pready tied 1 -> psel high N+1 with penable 0; penable high N+2; rsp_valid N+3 with rsp_rdata=0, rsp_error=0; pwdata stable across both phases.
- Read 0x00024, completer holds pready=0 for 3 cycles then returns prdata=0x12345678 -> paddr/psel/penable stable for 4 ACCESS cycles; rsp_rdata=0x12345678 at completion+1.
- Read with pslverr=1, prdata=0xA5A5A5A5 -> rsp_error=1, rsp_rdata=0xA5A5A5A5; rsp_ready held low 5 cycles -> rsp_* stable and req_ready=0 throughout.
- Back-to-back: two requests presented continuously with rsp_ready=1 -> second accepted exactly 4 cycles after the first.
- Assert rst during ACCESS -> next cycle psel=0, penable=0, rsp_valid=0, presetn=0; after release, a new request completes normally.
- With RENODE_APB3_MANAGER_TIMEOUT_EN and TimeoutCycles=4, pready stuck 0 -> rsp_error=1, rsp_rdata=0 after 4 wait cycles; psel drops the same cycle rsp_valid rises.

Source files
------------

// File: rtl/renode_apb3_manager.sv
// APB3 requester: one request at a time through SETUP/ACCESS, response on valid/ready.
// Optional ACCESS wait limit: define RENODE_APB3_MANAGER_TIMEOUT_EN.
module renode_apb3_manager #(
    parameter int AddressWidth  = 20,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 256
) (
    input  logic                    pclk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [AddressWidth-1:0] req_addr,
    input  logic                    req_write,
    input  logic [DataWidth-1:0]    req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DataWidth-1:0]    rsp_rdata,
    output logic                    rsp_error,
    output logic                    presetn,
    output logic [AddressWidth-1:0] paddr,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [DataWidth-1:0]    pwdata,
    input  logic                    pready,
    input  logic [DataWidth-1:0]    prdata,
    input  logic                    pslverr
);

    if (!(DataWidth == 8 || DataWidth == 16 ||
          DataWidth == 24 || DataWidth == 32)) begin : g_bad_data_width
        $error("renode_apb3_manager: DataWidth must be 8, 16, 24 or 32");
    end

    if (TimeoutCycles < 1) begin : g_bad_timeout
        $error("renode_apb3_manager: TimeoutCycles must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t                  state_q, state_d;
    logic                    psel_d, penable_d, pwrite_d;
    logic                    rsp_valid_d, rsp_error_d;
    logic [AddressWidth-1:0] paddr_d;
    logic [DataWidth-1:0]    pwdata_d, rsp_rdata_d;

`ifdef RENODE_APB3_MANAGER_TIMEOUT_EN
    localparam int CntWidth = $clog2(TimeoutCycles + 1);
    localparam logic [CntWidth-1:0] CntLimit = CntWidth'(TimeoutCycles - 1);

    logic [CntWidth-1:0] cnt_q, cnt_d;
`endif

    assign req_ready = (state_q == IDLE);

    always_comb begin
        state_d     = state_q;
        psel_d      = psel;
        penable_d   = penable;
        pwrite_d    = pwrite;
        paddr_d     = paddr;
        pwdata_d    = pwdata;
        rsp_valid_d = rsp_valid;
        rsp_rdata_d = rsp_rdata;
        rsp_error_d = rsp_error;
`ifdef RENODE_APB3_MANAGER_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    paddr_d   = req_addr;
                    pwrite_d  = req_write;
                    pwdata_d  = req_write ? req_wdata : '0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
`ifdef RENODE_APB3_MANAGER_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            ACCESS: begin
                if (pready) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_rdata_d = pwrite ? '0 : prdata;
                    rsp_error_d = pslverr;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
`ifdef RENODE_APB3_MANAGER_TIMEOUT_EN
                // This cycle is the last allowed pready-low cycle.
                else if (cnt_q == CntLimit) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_error_d = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        presetn <= ~rst;
        if (rst) begin
            state_q   <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
        end else begin
            state_q   <= state_d;
            psel      <= psel_d;
            penable   <= penable_d;
            pwrite    <= pwrite_d;
            paddr     <= paddr_d;
            pwdata    <= pwdata_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_error <= rsp_error_d;
        end
    end

`ifdef RENODE_APB3_MANAGER_TIMEOUT_EN
    always_ff @(posedge pclk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_renode_apb3_manager.sv
// Directed plus randomized bench for renode_apb3_manager.
// Timeout scenario runs only when RENODE_APB3_MANAGER_TIMEOUT_EN is defined.
module tb_renode_apb3_manager;

    localparam int AW = 20;
    localparam int DW = 32;

    logic          pclk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          req_write;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_error;
    logic          presetn;
    logic [AW-1:0] paddr;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic          pready;
    logic [DW-1:0] prdata;
    logic          pslverr;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc_cyc  = 0;

    renode_apb3_manager #(
        .AddressWidth (AW),
        .DataWidth    (DW),
        .TimeoutCycles(4)
    ) dut (
        .pclk     (pclk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .req_write(req_write),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error),
        .presetn  (presetn),
        .paddr    (paddr),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
        .pready   (pready),
        .prdata   (prdata),
        .pslverr  (pslverr)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transfer; expectations come straight from the request fields
    // and the completer behaviour chosen by the caller.
    task automatic do_xfer(input logic [AW-1:0] a, input logic w,
                           input logic [DW-1:0] wd, input int waits,
                           input logic [DW-1:0] rd, input logic er,
                           input int rdly);
        logic [DW-1:0] exp_wd;
        logic [DW-1:0] exp_rd;
        int n;
        exp_wd = w ? wd : '0;
        exp_rd = w ? '0 : rd;
        req_valid = 1'b1;
        req_addr  = a;
        req_write = w;
        req_wdata = wd;
        pready    = 1'b0;
        n = 0;
        while (!req_ready && n < 50) begin
            step();
            n++;
        end
        chk("accept_ready", req_ready, 1);
        step();
        acc_cyc   = cyc;
        req_valid = 1'b0;
        req_addr  = AW'($urandom);
        req_wdata = $urandom;
        chk("setup_psel", psel, 1);
        chk("setup_penable", penable, 0);
        chk("setup_paddr", paddr, a);
        chk("setup_pwrite", pwrite, w);
        chk("setup_pwdata", pwdata, exp_wd);
        chk("setup_req_ready", req_ready, 0);
        step();
        chk("access_psel", psel, 1);
        chk("access_penable", penable, 1);
        chk("access_pwdata", pwdata, exp_wd);
        chk("access_rsp_valid", rsp_valid, 0);
        for (int i = 0; i < waits; i++) begin
            pready = 1'b0;
            prdata = $urandom;
            step();
            chk("wait_psel", psel, 1);
            chk("wait_penable", penable, 1);
            chk("wait_paddr", paddr, a);
            chk("wait_pwdata", pwdata, exp_wd);
            chk("wait_rsp_valid", rsp_valid, 0);
        end
        pready    = 1'b1;
        prdata    = rd;
        pslverr   = er;
        rsp_ready = (rdly == 0);
        step();
        pready  = 1'b0;
        prdata  = $urandom;
        pslverr = 1'b1;
        chk("resp_psel", psel, 0);
        chk("resp_penable", penable, 0);
        chk("resp_valid", rsp_valid, 1);
        chk("resp_rdata", rsp_rdata, exp_rd);
        chk("resp_error", rsp_error, er);
        chk("resp_req_ready", req_ready, 0);
        for (int i = 0; i < rdly; i++) begin
            step();
            chk("hold_valid", rsp_valid, 1);
            chk("hold_rdata", rsp_rdata, exp_rd);
            chk("hold_error", rsp_error, er);
            chk("hold_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        pslverr   = 1'b0;
        chk("done_rsp_valid", rsp_valid, 0);
        chk("done_req_ready", req_ready, 1);
        chk("done_psel", psel, 0);
        chk("done_paddr_hold", paddr, a);
        chk("done_pwrite_hold", pwrite, w);
    endtask

    initial begin
        int first_acc;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_write = 1'b0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        pready    = 1'b0;
        prdata    = '0;
        pslverr   = 1'b0;
        repeat (3) step();
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_error", rsp_error, 0);
        chk("rst_presetn", presetn, 0);
        rst       = 1'b0;
        rsp_ready = 1'b0;
        step();
        chk("presetn_rise", presetn, 1);
        chk("idle_req_ready", req_ready, 1);

        do_xfer(20'h00010, 1'b1, 32'hDEADBEEF, 0, 32'h0, 1'b0, 0);
        do_xfer(20'h00024, 1'b0, 32'h0, 3, 32'h12345678, 1'b0, 0);
        do_xfer(20'h00030, 1'b0, 32'h0, 0, 32'hA5A5A5A5, 1'b1, 5);

        do_xfer(20'h00100, 1'b1, 32'h11111111, 0, 32'h0, 1'b0, 0);
        first_acc = acc_cyc;
        do_xfer(20'h00104, 1'b0, 32'h0, 0, 32'h22222222, 1'b0, 0);
        chk("b2b_spacing", 64'(acc_cyc - first_acc), 4);

        req_valid = 1'b1;
        req_addr  = 20'h00ABC;
        req_write = 1'b1;
        req_wdata = 32'hCAFEF00D;
        step();
        req_valid = 1'b0;
        step();
        chk("pre_rst_penable", penable, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_psel", psel, 0);
        chk("midrst_penable", penable, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_presetn", presetn, 0);
        step();
        chk("midrst_presetn_rise", presetn, 1);
        chk("midrst_rsp_valid2", rsp_valid, 0);
        do_xfer(20'h00200, 1'b0, 32'h0, 1, 32'h0BADC0DE, 1'b0, 1);

        for (int k = 0; k < 20; k++) begin
            do_xfer(AW'($urandom), 1'($urandom), $urandom,
                    int'($urandom_range(0, 3)), $urandom,
                    1'($urandom), int'($urandom_range(0, 2)));
        end

`ifdef RENODE_APB3_MANAGER_TIMEOUT_EN
        req_valid = 1'b1;
        req_addr  = 20'h00F00;
        req_write = 1'b0;
        pready    = 1'b0;
        step();
        req_valid = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("to_wait_psel", psel, 1);
            chk("to_wait_valid", rsp_valid, 0);
        end
        step();
        chk("to_psel", psel, 0);
        chk("to_penable", penable, 0);
        chk("to_valid", rsp_valid, 1);
        chk("to_error", rsp_error, 1);
        chk("to_rdata", rsp_rdata, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("to_done_valid", rsp_valid, 0);
        do_xfer(20'h00F04, 1'b0, 32'h0, 3, 32'h600DF00D, 1'b0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
